data_mem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 45 ++++
 rtl/data_mem_responder.sv | 144 ++++++++++++++
 tb/tb_data_mem_responder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state enum, wait-counter width and default sizing.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WCNT_W          = 4;
  localparam int DEF_DEPTH_WORDS = 1024;
  localparam int DEF_WAIT_STATES = 2;

endpackage

// File: rtl/dmem_array.sv
// Word array: synchronous byte-masked write, registered read.
// Ports: clk, reset, we_i, re_i, idx_i, wdata_i, be_i -> rdata_o.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        be_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Read register doubles as the response data:
  // zero whenever no successful load completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder with fixed wait states and one-cycle ready.
// Ports: clk, reset, mem_req/wr/addr/wdata[/be] -> mem_rdata/ready/err.
// Optional: DMEM_BYTE_LANES_EN adds mem_be[3:0] byte-lane stores.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
`ifdef DMEM_BYTE_LANES_EN
  input  logic [3:0]  mem_be,
`endif
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [WCNT_W-1:0] WCNT_INIT =
    (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  state_e              state_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic                wr_q;
  logic                bad_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic                ready_q;
  logic                err_q;

  logic [3:0]          be_in;
  logic                addr_bad;
  logic                resp_go;
  logic                cur_wr;
  logic                cur_bad;
  logic [ADDR_W-1:0]   cur_idx;
  logic [31:0]         cur_wdata;
  logic [3:0]          cur_be;
  logic                arr_we;
  logic                arr_re;

`ifdef DMEM_BYTE_LANES_EN
  assign be_in = mem_be;
`else
  assign be_in = 4'hF;
`endif

  // Full-address range check: no aliasing of high addresses.
  assign addr_bad = (mem_addr[1:0] != 2'b00) ||
                    ({2'b00, mem_addr[31:2]} >= 32'(DEPTH_WORDS));

  // With zero wait states the response is built from the live
  // request; otherwise from the values captured at accept.
  always_comb begin
    cur_wr    = wr_q;
    cur_bad   = bad_q;
    cur_idx   = idx_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    resp_go   = 1'b0;
    if (state_q == IDLE) begin
      cur_wr    = mem_wr;
      cur_bad   = addr_bad;
      cur_idx   = mem_addr[ADDR_W+1:2];
      cur_wdata = mem_wdata;
      cur_be    = be_in;
      resp_go   = NO_WAIT && mem_req;
    end else if (state_q == WAIT) begin
      resp_go   = (wcnt_q == '0);
    end
  end

  assign arr_we = resp_go && cur_wr && !cur_bad && !reset;
  assign arr_re = resp_go && !cur_wr && !cur_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= resp_go;
      err_q   <= resp_go && cur_bad;
      unique case (state_q)
        IDLE: begin
          if (mem_req) begin
            wr_q    <= mem_wr;
            bad_q   <= addr_bad;
            idx_q   <= mem_addr[ADDR_W+1:2];
            wdata_q <= mem_wdata;
            be_q    <= be_in;
            wcnt_q  <= WCNT_INIT;
            state_q <= NO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (wcnt_q == '0) begin
            state_q <= RESP;
          end else begin
            wcnt_q <= wcnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .idx_i   (cur_idx),
    .wdata_i (cur_wdata),
    .be_i    (cur_be),
    .rdata_o (mem_rdata)
  );

  assign mem_ready = ready_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (1024 words, 2 wait states).
// Covers timing, errors, async reset, back-to-back and byte lanes.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;

  int tests;
  int fails;

  data_mem_responder #(
    .DEPTH_WORDS (1024),
    .WAIT_STATES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
`ifdef DMEM_BYTE_LANES_EN
    .mem_be    (mem_be),
`endif
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_err   (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ready"}, 32'(mem_ready), 32'd0);
    chk({tag, ".err"},   32'(mem_err),   32'd0);
    chk({tag, ".rdata"}, mem_rdata,      32'd0);
  endtask

  // One transaction: ready must appear exactly in the third
  // negedge after the accept edge, then drop.
  task automatic xact(input string tag,
                      input logic wr,
                      input logic [31:0] addr,
                      input logic [31:0] wdata,
                      input logic [31:0] exp_rd,
                      input logic exp_err);
    @(negedge clk);
    mem_req   = 1'b1;
    mem_wr    = wr;
    mem_addr  = addr;
    mem_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".w1"}, 32'(mem_ready), 32'd0);
    @(negedge clk);
    chk({tag, ".w2"}, 32'(mem_ready), 32'd0);
    @(negedge clk);
    chk({tag, ".ready"}, 32'(mem_ready), 32'd1);
    chk({tag, ".err"},   32'(mem_err),   32'(exp_err));
    chk({tag, ".rdata"}, mem_rdata,      exp_rd);
    mem_req = 1'b0;
    @(negedge clk);
    chk_idle({tag, ".after"});
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'hF;

    repeat (2) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;

    xact("st10",   1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
    xact("ld10",   1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    xact("stmis",  1'b1, 32'h13,  32'hFFFFFFFF, 32'h0,        1'b1);
    xact("ld10b",  1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    xact("ldoor",  1'b0, 32'h1000, 32'h0,       32'h0,        1'b1);
    xact("stffc",  1'b1, 32'hFFC, 32'hA5A50FFC, 32'h0,        1'b0);
    xact("ldffc",  1'b0, 32'hFFC, 32'h0,        32'hA5A50FFC, 1'b0);
    xact("ldalias",1'b0, 32'hFFFFF010, 32'h0,   32'h0,        1'b1);
    xact("st20",   1'b1, 32'h20,  32'hCAFEF00D, 32'h0,        1'b0);

    // Reset during WAIT of a store: store must be discarded.
    @(negedge clk);
    mem_req   = 1'b1;
    mem_wr    = 1'b1;
    mem_addr  = 32'h20;
    mem_wdata = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    mem_req = 1'b0;
    #1;
    chk_idle("rstwait");
    @(negedge clk);
    @(negedge clk);
    chk_idle("rstwait.hold");
    reset = 1'b0;
    xact("ld20", 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

    // Reset in the ready cycle clears outputs asynchronously.
    @(negedge clk);
    mem_req  = 1'b1;
    mem_wr   = 1'b0;
    mem_addr = 32'h10;
    @(posedge clk);
    repeat (3) @(negedge clk);
    chk("rstresp.pre", mem_rdata, 32'hDEADBEEF);
    reset   = 1'b1;
    mem_req = 1'b0;
    #1;
    chk_idle("rstresp");
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back: req held high, ready at i=3 and i=7 only.
    @(negedge clk);
    mem_req  = 1'b1;
    mem_wr   = 1'b0;
    mem_addr = 32'h10;
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("b2b.rdy%0d", i), 32'(mem_ready),
          (i == 3 || i == 7) ? 32'd1 : 32'd0);
      if (i == 3 || i == 7)
        chk($sformatf("b2b.rd%0d", i), mem_rdata, 32'hDEADBEEF);
      if (i == 7)
        mem_req = 1'b0;
    end

`ifdef DMEM_BYTE_LANES_EN
    mem_be = 4'b0011;
    xact("stbe", 1'b1, 32'h10, 32'h12345678, 32'h0, 1'b0);
    mem_be = 4'b0000;
    xact("stbe0", 1'b1, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b0);
    mem_be = 4'b1111;
    xact("ldbe", 1'b0, 32'h10, 32'h0, 32'hDEAD5678, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
